rr_arbiter8: RTL and testbench

//  Arbitrates N requesters (default 8) for one shared resource.

---
 rtl/rr_arbiter8.sv | 111 +++++++++++
 tb/tb_rr_arbiter8.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Registered N-way arbiter: fixed (highest index) or round-robin selection,
// grant held while the winner keeps requesting, bounded by a hold timeout.
module rr_arbiter8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fixed_pri,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 timeout
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state, state_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [N-1:0]  grant_d;
    logic          valid_d;
    logic [IW-1:0] id_d;
    logic          timeout_d;

    logic [IW-1:0] start;
    logic [IW-1:0] pidx;
    logic          win_found;
    logic [IW-1:0] win_id;

    // Descending wrap-around search from start; first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        pidx      = '0;
        start     = fixed_pri ? IW'(N - 1) : ptr;
        for (int unsigned k = 0; k < N; k++) begin
            pidx = IW'((32'(start) + N - k) % N);
            if (!win_found && req[pidx]) begin
                win_found = 1'b1;
                win_id    = pidx;
            end
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        grant_d   = grant;
        valid_d   = grant_valid;
        id_d      = grant_id;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                id_d    = '0;
                hold_d  = '0;
                if (win_found) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win_id;
                    valid_d = 1'b1;
                    id_d    = win_id;
                    hold_d  = HW'(1);
                    ptr_d   = (win_id == '0) ? IW'(N - 1) : win_id - IW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_id] || hold_cnt == HW'(MAX_HOLD)) begin
                    // A release wins over a coincident timeout.
                    timeout_d = req[grant_id];
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    id_d      = '0;
                    hold_d    = '0;
                    state_d   = IDLE;
                end else begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= IW'(N - 1);
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            hold_cnt    <= hold_d;
            grant       <= grant_d;
            grant_valid <= valid_d;
            grant_id    <= id_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, fixed priority, round-robin,
// timeout, release-at-timeout and reset mid-grant.
module tb_rr_arbiter8;

    localparam int unsigned MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       fixed_pri;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.N(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .fixed_pri  (fixed_pri),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .timeout    (timeout)
    );

    a_onehot: assert property (@(negedge clk) disable iff (reset) $onehot0(grant))
        else begin failures++; $display("FAIL inv_onehot grant=%h", grant); end
    a_valid: assert property (@(negedge clk) disable iff (reset) grant_valid == (|grant))
        else begin failures++; $display("FAIL inv_valid valid=%b grant=%h", grant_valid, grant); end
    a_id: assert property (@(negedge clk) disable iff (reset)
            grant_valid ? (grant == (8'd1 << grant_id)) : (grant_id == 3'd0))
        else begin failures++; $display("FAIL inv_id id=%0d grant=%h", grant_id, grant); end
    a_hold: assert property (@(negedge clk) disable iff (reset) dut.hold_cnt <= 5'(MAX_HOLD))
        else begin failures++; $display("FAIL inv_hold hold_cnt=%0d", dut.hold_cnt); end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] r, input logic fp);
        reset     = 1'b1;
        req       = r;
        fixed_pri = fp;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req       = 8'hFF;
        fixed_pri = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got grant=%h valid=%b id=%0d to=%b exp all zero",
                     grant, grant_valid, grant_id, timeout);
        end
        checks++;
        if (dut.ptr !== 3'd7) begin
            failures++; $display("FAIL reset_ptr got=%0d exp=7", dut.ptr);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h80 || grant_id !== 3'd7 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant got grant=%h id=%0d valid=%b exp 80/7/1",
                     grant, grant_id, grant_valid);
        end
    endtask

    task automatic test_fixed();
        logic [2:0] ids  [4] = '{3'd7, 3'd4, 3'd1, 3'd0};
        int         hold [4] = '{3, 1, 1, 1};
        apply_reset(8'b1001_0011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < hold[i]; c++) begin
                tick();
                checks++;
                if (grant !== (8'd1 << ids[i]) || grant_id !== ids[i]) begin
                    failures++;
                    $display("FAIL fixed_grant[%0d] got grant=%h id=%0d exp id=%0d", i, grant, grant_id, ids[i]);
                end
            end
            req[ids[i]] = 1'b0;
            tick();
            checks++;
            if (grant !== 8'h00) begin
                failures++; $display("FAIL fixed_gap[%0d] got=%h exp=00", i, grant);
            end
        end
        tick();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            failures++; $display("FAIL fixed_idle got=%h exp=00", grant);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_id;
        apply_reset(8'hFF, 1'b0);
        for (int i = 0; i < 9; i++) begin
            exp_id = 3'(7 - i);
            tick();
            checks++;
            if (grant !== (8'd1 << exp_id) || grant_id !== exp_id) begin
                failures++;
                $display("FAIL rr_grant[%0d] got grant=%h id=%0d exp id=%0d", i, grant, grant_id, exp_id);
            end
            req[exp_id] = 1'b0;
            tick();
            checks++;
            if (grant !== 8'h00 || timeout !== 1'b0) begin
                failures++; $display("FAIL rr_gap[%0d] got grant=%h to=%b exp 00/0", i, grant, timeout);
            end
            req[exp_id] = 1'b1;
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        apply_reset(8'h04, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if (grant !== 8'h04 || timeout !== 1'b0) begin
                failures++; $display("FAIL to_hold1[%0d] got grant=%h to=%b exp 04/0", c, grant, timeout);
            end
        end
        tick();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b1) begin
            failures++; $display("FAIL to_pulse1 got grant=%h to=%b exp 00/1", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 8'h04 || grant_id !== 3'd2 || timeout !== 1'b0) begin
            failures++; $display("FAIL to_regrant got grant=%h to=%b exp 04/0", grant, timeout);
        end
        req = 8'h0C;
        for (int c = 2; c <= 16; c++) begin
            tick();
            checks++;
            if (grant !== 8'h04) begin
                failures++; $display("FAIL to_hold2[%0d] got=%h exp=04", c, grant);
            end
        end
        tick();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b1) begin
            failures++; $display("FAIL to_pulse2 got grant=%h to=%b exp 00/1", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 8'h08 || grant_id !== 3'd3 || timeout !== 1'b0) begin
            failures++; $display("FAIL to_other_wins got grant=%h id=%0d exp 08/3", grant, grant_id);
        end
        req = 8'h00;
        tick();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            failures++; $display("FAIL to_release got grant=%h to=%b exp 00/0", grant, timeout);
        end
    endtask

    task automatic test_release_at_timeout();
        apply_reset(8'h04, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if (grant !== 8'h04) begin
                failures++; $display("FAIL rat_hold[%0d] got=%h exp=04", c, grant);
            end
            if (c == 16) req = 8'h00;
        end
        tick();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            failures++; $display("FAIL rat_release got grant=%h to=%b exp 00/0", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            failures++; $display("FAIL rat_idle got grant=%h to=%b exp 00/0", grant, timeout);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset(8'h20, 1'b0);
        tick();
        tick();
        checks++;
        if (grant !== 8'h20) begin
            failures++; $display("FAIL rmg_pre got=%h exp=20", grant);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            failures++; $display("FAIL rmg_async got grant=%h valid=%b exp 00/0", grant, grant_valid);
        end
        checks++;
        if (dut.ptr !== 3'd7) begin
            failures++; $display("FAIL rmg_ptr got=%0d exp=7", dut.ptr);
        end
        req = 8'h01;
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h01 || grant_id !== 3'd0 || grant_valid !== 1'b1) begin
            failures++; $display("FAIL rmg_regrant got grant=%h id=%0d exp 01/0", grant, grant_id);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_release_at_timeout();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
